bus_read_master: RTL and testbench

- CPU-side initiator for the combinational program memory: drives a 16-bit byte address and samples the 8-bit data returned in the same cycle.
- Serves core read requests: single byte, 16-bit little-endian word, and word with 6502 page-wrap (JMP-indirect quirk).
- Out of reset, autonomously fetches the reset vector and presents the initial PC.
- Read-only master; no write path.

---
 rtl/bus_read_master_if.sv | 24 ++
 rtl/bus_read_master.sv | 118 +++++++++++
 tb/tb_bus_read_master.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bus_read_master_if.sv
// Request/response and program-memory signals of the CPU-side read master.
// The master modport is the DUT's view; the slave modport is the core and memory side.
interface bus_read_master_if;
    logic        req;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        vec_valid;
    logic [15:0] vec_pc;
    logic [15:0] mem_address;
    logic [7:0]  mem_data;

    modport master (
        input  req, req_op, req_addr, mem_data,
        output busy, done, rdata, vec_valid, vec_pc, mem_address
    );

    modport slave (
        output req, req_op, req_addr, mem_data,
        input  busy, done, rdata, vec_valid, vec_pc, mem_address
    );
endinterface

// File: rtl/bus_read_master.sv
// Read-only initiator for the combinational program memory: fetches the reset
// vector out of reset, then serves byte, linear-word and page-wrap-word reads.
module bus_read_master #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic               clk,
    input  logic               rst,
    bus_read_master_if.master  bus
);

    typedef enum logic [2:0] {
        VEC_LO,
        VEC_HI,
        IDLE,
        RD_LO,
        RD_HI
    } state_t;

    state_t      state, state_n;
    logic [1:0]  op_q, op_n;
    logic [15:0] addr_q, addr_n;
    logic [15:0] mem_address_n;
    logic        busy_n;
    logic        done_n;
    logic [15:0] rdata_n;
    logic        vec_valid_n;
    logic [15:0] vec_pc_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= VEC_LO;
            op_q            <= 2'b00;
            addr_q          <= 16'h0000;
            bus.mem_address <= RESET_VECTOR;
            bus.busy        <= 1'b1;
            bus.done        <= 1'b0;
            bus.rdata       <= 16'h0000;
            bus.vec_valid   <= 1'b0;
            bus.vec_pc      <= 16'h0000;
        end else begin
            state           <= state_n;
            op_q            <= op_n;
            addr_q          <= addr_n;
            bus.mem_address <= mem_address_n;
            bus.busy        <= busy_n;
            bus.done        <= done_n;
            bus.rdata       <= rdata_n;
            bus.vec_valid   <= vec_valid_n;
            bus.vec_pc      <= vec_pc_n;
        end
    end

    // Memory answers combinationally, so each state samples mem_data for the
    // address it set up one edge earlier: one cycle per byte.
    always_comb begin
        state_n       = state;
        op_n          = op_q;
        addr_n        = addr_q;
        mem_address_n = bus.mem_address;
        busy_n        = bus.busy;
        done_n        = 1'b0;
        rdata_n       = bus.rdata;
        vec_valid_n   = bus.vec_valid;
        vec_pc_n      = bus.vec_pc;

        case (state)
            VEC_LO: begin
                vec_pc_n[7:0] = bus.mem_data;
                mem_address_n = RESET_VECTOR + 16'd1;
                state_n       = VEC_HI;
            end
            VEC_HI: begin
                vec_pc_n[15:8] = bus.mem_data;
                vec_valid_n    = 1'b1;
                busy_n         = 1'b0;
                state_n        = IDLE;
            end
            IDLE: begin
                if (bus.req) begin
                    mem_address_n = bus.req_addr;
                    op_n          = bus.req_op;
                    addr_n        = bus.req_addr;
                    busy_n        = 1'b1;
                    state_n       = RD_LO;
                end
            end
            RD_LO: begin
                rdata_n = {8'h00, bus.mem_data};
                case (op_q)
                    2'b01: begin
                        mem_address_n = addr_q + 16'd1;
                        state_n       = RD_HI;
                    end
                    // 6502 JMP-indirect quirk: the high byte comes from the same page
                    2'b10: begin
                        mem_address_n = {addr_q[15:8], addr_q[7:0] + 8'd1};
                        state_n       = RD_HI;
                    end
                    default: begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                endcase
            end
            RD_HI: begin
                rdata_n[15:8] = bus.mem_data;
                done_n        = 1'b1;
                busy_n        = 1'b0;
                state_n       = IDLE;
            end
            default: begin
                state_n = VEC_LO;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_read_master.sv
// Directed self-checking bench for bus_read_master with a 64 KiB memory model.
module tb_bus_read_master;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] mem [0:65535];

    bus_read_master_if bus ();

    bus_read_master #(.RESET_VECTOR(16'hFFFC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_data = mem[bus.mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] addr);
        bus.req      = 1'b1;
        bus.req_op   = op;
        bus.req_addr = addr;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic readByte(input string tag, input logic [1:0] op, input logic [15:0] addr,
                            input logic [15:0] expected);
        applyStimulus(op, addr);
        checkOutput({tag, "_addr"}, bus.mem_address, addr);
        checkOutput({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
        checkOutput({tag, "_nodone"}, {15'd0, bus.done}, 16'd0);
        tick();
        checkOutput({tag, "_done"}, {15'd0, bus.done}, 16'd1);
        checkOutput({tag, "_rdata"}, bus.rdata, expected);
        checkOutput({tag, "_idle"}, {15'd0, bus.busy}, 16'd0);
        tick();
        checkOutput({tag, "_done_clr"}, {15'd0, bus.done}, 16'd0);
        checkOutput({tag, "_hold"}, bus.rdata, expected);
    endtask

    task automatic readWord(input string tag, input logic [1:0] op, input logic [15:0] addr,
                            input logic [15:0] addr_hi, input logic [15:0] expected);
        applyStimulus(op, addr);
        checkOutput({tag, "_addr_lo"}, bus.mem_address, addr);
        checkOutput({tag, "_nodone0"}, {15'd0, bus.done}, 16'd0);
        tick();
        checkOutput({tag, "_addr_hi"}, bus.mem_address, addr_hi);
        checkOutput({tag, "_nodone1"}, {15'd0, bus.done}, 16'd0);
        checkOutput({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
        tick();
        checkOutput({tag, "_done"}, {15'd0, bus.done}, 16'd1);
        checkOutput({tag, "_rdata"}, bus.rdata, expected);
        checkOutput({tag, "_idle"}, {15'd0, bus.busy}, 16'd0);
        tick();
        checkOutput({tag, "_done_clr"}, {15'd0, bus.done}, 16'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.req      = 1'b0;
        bus.req_op   = 2'b00;
        bus.req_addr = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'hC0;
        mem[16'h1234] = 8'hA9;
        mem[16'h12FF] = 8'h34;
        mem[16'h1300] = 8'h12;
        mem[16'h1200] = 8'h56;
        mem[16'hFFFF] = 8'hEF;
        mem[16'h0000] = 8'hBE;

        #12;
        checkOutput("rst_busy", {15'd0, bus.busy}, 16'd1);
        checkOutput("rst_done", {15'd0, bus.done}, 16'd0);
        checkOutput("rst_rdata", bus.rdata, 16'h0000);
        checkOutput("rst_vec_valid", {15'd0, bus.vec_valid}, 16'd0);
        checkOutput("rst_vec_pc", bus.vec_pc, 16'h0000);
        checkOutput("rst_addr", bus.mem_address, 16'hFFFC);

        rst = 1'b0;
        tick();
        checkOutput("vec_addr_hi", bus.mem_address, 16'hFFFD);
        checkOutput("vec_valid_early", {15'd0, bus.vec_valid}, 16'd0);
        checkOutput("vec_nodone0", {15'd0, bus.done}, 16'd0);
        tick();
        checkOutput("vec_pc", bus.vec_pc, 16'hC000);
        checkOutput("vec_valid", {15'd0, bus.vec_valid}, 16'd1);
        checkOutput("vec_busy", {15'd0, bus.busy}, 16'd0);
        checkOutput("vec_nodone1", {15'd0, bus.done}, 16'd0);

        readByte("byte", 2'b00, 16'h1234, 16'h00A9);
        readByte("op11", 2'b11, 16'h12FF, 16'h0034);
        readWord("lin", 2'b01, 16'h12FF, 16'h1300, 16'h1234);
        readWord("wrap", 2'b10, 16'h12FF, 16'h1200, 16'h5634);
        readWord("space", 2'b01, 16'hFFFF, 16'h0000, 16'hBEEF);

        // A request held while busy is dropped and the latched op/addr are kept
        applyStimulus(2'b01, 16'h12FF);
        bus.req      = 1'b1;
        bus.req_op   = 2'b00;
        bus.req_addr = 16'h2222;
        tick();
        bus.req = 1'b0;
        checkOutput("drop_addr_hi", bus.mem_address, 16'h1300);
        checkOutput("drop_nodone", {15'd0, bus.done}, 16'd0);
        tick();
        checkOutput("drop_done", {15'd0, bus.done}, 16'd1);
        checkOutput("drop_rdata", bus.rdata, 16'h1234);
        tick();
        checkOutput("drop_single_pulse", {15'd0, bus.done}, 16'd0);
        checkOutput("drop_not_taken", {15'd0, bus.busy}, 16'd0);
        checkOutput("drop_addr_kept", bus.mem_address, 16'h1300);

        // Request raised in the done cycle is taken at the very next edge
        applyStimulus(2'b00, 16'h1234);
        tick();
        checkOutput("b2b_done1", {15'd0, bus.done}, 16'd1);
        checkOutput("b2b_free", {15'd0, bus.busy}, 16'd0);
        bus.req      = 1'b1;
        bus.req_op   = 2'b00;
        bus.req_addr = 16'h0000;
        tick();
        bus.req = 1'b0;
        checkOutput("b2b_accept", {15'd0, bus.busy}, 16'd1);
        checkOutput("b2b_addr", bus.mem_address, 16'h0000);
        checkOutput("b2b_done_clr", {15'd0, bus.done}, 16'd0);
        tick();
        checkOutput("b2b_done2", {15'd0, bus.done}, 16'd1);
        checkOutput("b2b_rdata", bus.rdata, 16'h00BE);

        // Reset while in RD_HI aborts the read and restarts the vector fetch
        applyStimulus(2'b10, 16'h12FF);
        tick();
        checkOutput("abort_in_hi", bus.mem_address, 16'h1200);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {15'd0, bus.busy}, 16'd1);
        checkOutput("abort_done", {15'd0, bus.done}, 16'd0);
        checkOutput("abort_rdata", bus.rdata, 16'h0000);
        checkOutput("abort_vec_valid", {15'd0, bus.vec_valid}, 16'd0);
        checkOutput("abort_addr", bus.mem_address, 16'hFFFC);
        #2;
        rst          = 1'b0;
        bus.req      = 1'b1;
        bus.req_op   = 2'b00;
        bus.req_addr = 16'h1234;
        tick();
        checkOutput("refetch_addr_hi", bus.mem_address, 16'hFFFD);
        checkOutput("refetch_nodone0", {15'd0, bus.done}, 16'd0);
        tick();
        bus.req = 1'b0;
        checkOutput("refetch_vec_pc", bus.vec_pc, 16'hC000);
        checkOutput("refetch_vec_valid", {15'd0, bus.vec_valid}, 16'd1);
        checkOutput("refetch_busy", {15'd0, bus.busy}, 16'd0);
        checkOutput("refetch_nodone1", {15'd0, bus.done}, 16'd0);
        tick();
        checkOutput("fetch_req_ignored", {15'd0, bus.busy}, 16'd0);
        checkOutput("fetch_req_addr", bus.mem_address, 16'hFFFD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
